wb_arbiter: RTL and testbench

//  Writeback end of the execute pipes: consumes results from the single-cycle ALU

---
 rtl/wb_arbiter_if.sv | 44 ++++
 rtl/wb_arbiter.sv | 161 ++++++++++++++++
 tb/tb_wb_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Writeback bus bundle for wb_arbiter: ALU and multiply result inputs on one
// side, register-file write port and status outputs on the other.
`ifndef REG_SIZE
`define REG_SIZE 32
`endif

interface wb_arbiter_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = `REG_SIZE,
    parameter int ADDR_W = 5
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_dst;
    logic [DATA_W-1:0] alu_result;
    logic              alu_overflow;
    logic              m5_valid;
    logic [ADDR_W-1:0] m5_dst;
    logic [DATA_W-1:0] m5result;
    logic              m5_overflow;
    logic              alu_stall;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [CNT_W-1:0]  pending;
    logic              drop_err;
    logic              exc_ovf;
    logic [ADDR_W-1:0] exc_dst;

    // Execute-side producer and register-file consumer
    modport master (
        output alu_valid, alu_dst, alu_result, alu_overflow,
        output m5_valid, m5_dst, m5result, m5_overflow,
        input  alu_stall, rf_we, rf_waddr, rf_wdata, pending, drop_err, exc_ovf, exc_dst
    );

    // The arbiter itself
    modport slave (
        input  alu_valid, alu_dst, alu_result, alu_overflow,
        input  m5_valid, m5_dst, m5result, m5_overflow,
        output alu_stall, rf_we, rf_waddr, rf_wdata, pending, drop_err, exc_ovf, exc_dst
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the ALU path and the 5-stage multiply tail onto one
// register-file write port. Multiply always wins; displaced ALU results queue
// in an in-order FIFO and alu_stall is raised while it is full.
// Optional feature macro: WB_OVF_EXC_EN (overflowing results raise exc_ovf
// instead of being written).
`ifndef REG_SIZE
`define REG_SIZE 32
`endif

module wb_arbiter #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = `REG_SIZE,
    parameter int ADDR_W = 5
) (
    input logic        clk,
    input logic        reset,
    wb_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] q_dst  [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
`ifdef WB_OVF_EXC_EN
    logic              q_ovf  [DEPTH];
`endif
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  pending;
    logic              drop_err;

    logic              full;
    logic              fifo_empty;
    logic              m5_win;
    logic              alu_live;
    logic              push;
    logic              pop;
    logic              sel_valid;
    logic [ADDR_W-1:0] sel_dst;
    logic [DATA_W-1:0] sel_data;
    logic              sel_ovf;

    logic              rf_we_q;
    logic [ADDR_W-1:0] rf_waddr_q;
    logic [DATA_W-1:0] rf_wdata_q;

    assign full       = (pending == CNT_W'(DEPTH));
    assign fifo_empty = (pending == '0);

    // Port selection and FIFO push/pop decisions
    always_comb begin
        m5_win    = bus.m5_valid && (bus.m5_dst != '0);
        alu_live  = bus.alu_valid && (bus.alu_dst != '0) && !full;
        pop       = !m5_win && !fifo_empty;
        push      = alu_live && (m5_win || !fifo_empty);
        sel_valid = 1'b0;
        sel_dst   = '0;
        sel_data  = '0;
        sel_ovf   = 1'b0;
        if (m5_win) begin
            sel_valid = 1'b1;
            sel_dst   = bus.m5_dst;
            sel_data  = bus.m5result;
            sel_ovf   = bus.m5_overflow;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_dst   = q_dst[rd_ptr];
            sel_data  = q_data[rd_ptr];
`ifdef WB_OVF_EXC_EN
            sel_ovf   = q_ovf[rd_ptr];
`endif
        end else if (alu_live) begin
            sel_valid = 1'b1;
            sel_dst   = bus.alu_dst;
            sel_data  = bus.alu_result;
            sel_ovf   = bus.alu_overflow;
        end
    end

    // FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            q_dst[wr_ptr]  <= bus.alu_dst;
            q_data[wr_ptr] <= bus.alu_result;
`ifdef WB_OVF_EXC_EN
            q_ovf[wr_ptr]  <= bus.alu_overflow;
`endif
        end
    end

    // FIFO pointers, occupancy and sticky drop flag
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            pending  <= '0;
            drop_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      pending <= pending + CNT_W'(1);
            else if (pop && !push) pending <= pending - CNT_W'(1);
            if (bus.alu_valid && full) drop_err <= 1'b1;
        end
    end

`ifdef WB_OVF_EXC_EN
    logic              exc_ovf_q;
    logic [ADDR_W-1:0] exc_dst_q;

    // Registered write port; overflowing winners become an exception pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            exc_ovf_q  <= 1'b0;
            exc_dst_q  <= '0;
        end else begin
            rf_we_q   <= sel_valid && !sel_ovf;
            exc_ovf_q <= sel_valid && sel_ovf;
            if (sel_valid && !sel_ovf) begin
                rf_waddr_q <= sel_dst;
                rf_wdata_q <= sel_data;
            end
            if (sel_valid && sel_ovf) exc_dst_q <= sel_dst;
        end
    end

    assign bus.exc_ovf = exc_ovf_q;
    assign bus.exc_dst = exc_dst_q;
`else
    logic ovf_unused;
    assign ovf_unused = sel_ovf;

    // Registered write port; address/data hold while idle
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q <= sel_valid;
            if (sel_valid) begin
                rf_waddr_q <= sel_dst;
                rf_wdata_q <= sel_data;
            end
        end
    end

    assign bus.exc_ovf = 1'b0;
    assign bus.exc_dst = '0;
`endif

    assign bus.alu_stall = full;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.pending   = pending;
    assign bus.drop_err  = drop_err;
endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios followed by randomized traffic,
// all checked against a queue-based reference model of the writeback rules.
`ifndef REG_SIZE
`define REG_SIZE 32
`endif

module tb_wb_arbiter;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_arbiter_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    wb_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [ADDR_W-1:0] dst;
        logic [DATA_W-1:0] data;
        logic              ovf;
    } ent_t;

    ent_t              q[$];
    logic              exp_we;
    logic [ADDR_W-1:0] exp_waddr;
    logic [DATA_W-1:0] exp_wdata;
    logic              exp_drop;
    logic              exp_exc;
    logic [ADDR_W-1:0] exp_exc_dst;
    int                checks   = 0;
    int                failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: one clock of the writeback rules applied to the queue
    task automatic model_step();
        ent_t w;
        ent_t a;
        bit   have;
        bit   stall;
        bit   alu_ok;
        have = 1'b0;
        if (reset) begin
            q.delete();
            exp_we = 0; exp_waddr = '0; exp_wdata = '0;
            exp_drop = 0; exp_exc = 0; exp_exc_dst = '0;
            return;
        end
        stall  = (q.size() == DEPTH);
        if (bus.alu_valid && stall) exp_drop = 1'b1;
        alu_ok = bus.alu_valid && (bus.alu_dst != '0) && !stall;
        a = '{dst: bus.alu_dst, data: bus.alu_result, ovf: bus.alu_overflow};
        if (bus.m5_valid && bus.m5_dst != '0) begin
            w = '{dst: bus.m5_dst, data: bus.m5result, ovf: bus.m5_overflow};
            have = 1'b1;
            if (alu_ok) q.push_back(a);
        end else if (q.size() > 0) begin
            w = q.pop_front();
            have = 1'b1;
            if (alu_ok) q.push_back(a);
        end else if (alu_ok) begin
            w = a;
            have = 1'b1;
        end
        exp_we  = 1'b0;
        exp_exc = 1'b0;
`ifdef WB_OVF_EXC_EN
        if (have && w.ovf) begin
            exp_exc     = 1'b1;
            exp_exc_dst = w.dst;
            have        = 1'b0;
        end
`endif
        if (have) begin
            exp_we    = 1'b1;
            exp_waddr = w.dst;
            exp_wdata = w.data;
        end
    endtask

    // Drive one cycle of inputs, advance the clock, compare every output
    task automatic cyc(input bit rst,
                       input bit av, input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] ar, input bit ao,
                       input bit mv, input logic [ADDR_W-1:0] md, input logic [DATA_W-1:0] mr, input bit mo);
        reset            = rst;
        bus.alu_valid    = av;
        bus.alu_dst      = ad;
        bus.alu_result   = ar;
        bus.alu_overflow = ao;
        bus.m5_valid     = mv;
        bus.m5_dst       = md;
        bus.m5result     = mr;
        bus.m5_overflow  = mo;
        model_step();
        @(posedge clk);
        #1;
        check("rf_we",     32'(bus.rf_we),     32'(exp_we));
        check("rf_waddr",  32'(bus.rf_waddr),  32'(exp_waddr));
        check("rf_wdata",  bus.rf_wdata,       exp_wdata);
        check("pending",   32'(bus.pending),   32'(q.size()));
        check("alu_stall", 32'(bus.alu_stall), 32'(q.size() == DEPTH));
        check("drop_err",  32'(bus.drop_err),  32'(exp_drop));
        check("exc_ovf",   32'(bus.exc_ovf),   32'(exp_exc));
        check("exc_dst",   32'(bus.exc_dst),   32'(exp_exc_dst));
    endtask

    task automatic idle();
        cyc(0, 0, '0, '0, 0, 0, '0, '0, 0);
    endtask

    initial begin
        // Reset state
        cyc(1, 0, '0, '0, 0, 0, '0, '0, 0);
        cyc(1, 0, '0, '0, 0, 0, '0, '0, 0);
        check("rst_we", 32'(bus.rf_we), 32'd0);
        idle();

        // Lone ALU result goes straight through
        cyc(0, 1, 5'd3, 32'h11, 0, 0, '0, '0, 0);
        check("t1_waddr", 32'(bus.rf_waddr), 32'd3);
        check("t1_wdata", bus.rf_wdata, 32'h11);
        idle();

        // Collision: M5 first, ALU next cycle from the FIFO
        cyc(0, 1, 5'd5, 32'hBB, 0, 1, 5'd4, 32'hAA, 0);
        check("t2_m5_addr", 32'(bus.rf_waddr), 32'd4);
        check("t2_pend1", 32'(bus.pending), 32'd1);
        idle();
        check("t2_alu_addr", 32'(bus.rf_waddr), 32'd5);
        check("t2_alu_data", bus.rf_wdata, 32'hBB);

        // Sustained M5 fills the FIFO; extra ALU results are dropped
        for (int i = 0; i < 6; i++)
            cyc(0, 1, 5'(10 + i), 32'h100 + 32'(i), 0, 1, 5'(20 + i), 32'h200 + 32'(i), 0);
        check("t3_stall", 32'(bus.alu_stall), 32'd1);
        check("t3_drop", 32'(bus.drop_err), 32'd1);
        for (int i = 0; i < 4; i++) begin
            idle();
            check("t3_order", 32'(bus.rf_waddr), 32'(10 + i));
        end
        idle();

        // Zero destinations are discarded
        cyc(0, 1, 5'd0, 32'h55, 0, 1, 5'd0, 32'h66, 0);
        check("t4_no_we", 32'(bus.rf_we), 32'd0);
        cyc(0, 1, 5'd7, 32'h77, 0, 1, 5'd0, 32'h88, 0);
        check("t4_r7", 32'(bus.rf_waddr), 32'd7);

        // Reset with entries queued discards them
        for (int i = 0; i < 3; i++)
            cyc(0, 1, 5'(1 + i), 32'h300 + 32'(i), 0, 1, 5'(17 + i), 32'h400, 0);
        check("t5_pend3", 32'(bus.pending), 32'd3);
        cyc(1, 0, '0, '0, 0, 0, '0, '0, 0);
        for (int i = 0; i < 3; i++) begin
            idle();
            check("t5_no_stale", 32'(bus.rf_we), 32'd0);
        end

        // Overflowing multiply result
        cyc(0, 0, '0, '0, 0, 1, 5'd9, 32'h99, 1);
`ifdef WB_OVF_EXC_EN
        check("t6_exc", 32'(bus.exc_ovf), 32'd1);
        check("t6_we", 32'(bus.rf_we), 32'd0);
`else
        check("t6_exc", 32'(bus.exc_ovf), 32'd0);
        check("t6_we", 32'(bus.rf_we), 32'd1);
`endif
        idle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit                rst;
            bit                av;
            bit                mv;
            logic [ADDR_W-1:0] ad;
            logic [ADDR_W-1:0] md;
            rst = ($urandom_range(0, 299) == 0);
            mv  = ($urandom_range(0, 99) < 50);
            if (q.size() == DEPTH) av = ($urandom_range(0, 99) < 5);
            else                   av = ($urandom_range(0, 99) < 60);
            ad = ($urandom_range(0, 9) == 0) ? '0 : ADDR_W'($urandom_range(0, 31));
            md = ($urandom_range(0, 9) == 0) ? '0 : ADDR_W'($urandom_range(0, 31));
            cyc(rst, av, ad, $urandom, ($urandom_range(0, 3) == 0),
                mv, md, $urandom, ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
